// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        im_wen;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    // Host side: drives the byte stream, observes the memory writes.
    modport master (
        output in_data, in_valid,
        input  in_ready, im_wen, im_addr, im_wdata
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, im_wen, im_addr, im_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream, writes 32-bit words into
// instruction memory and holds the core in reset until a frame checks out.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus,
    output logic         cpu_rst_n,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  words_ld
);

    localparam int unsigned W_ADDR = 32;
    localparam int unsigned W_CNT  = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e              state_q,     state_d;
    logic [7:0]          n_lo_q,      n_lo_d;
    logic [W_CNT-1:0]    n_q,         n_d;
    logic [1:0]          lane_q,      lane_d;
    logic [23:0]         word_q,      word_d;
    logic [7:0]          acc_q,       acc_d;
    logic                im_wen_q,    im_wen_d;
    logic [W_ADDR-1:0]   im_addr_q,   im_addr_d;
    logic [31:0]         im_wdata_q,  im_wdata_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;
    logic [W_CNT-1:0]    words_ld_q,  words_ld_d;

    logic                accept;
    logic [W_CNT-1:0]    n_rx;

    // Ready is a pure function of state; only the error state refuses bytes.
    assign bus.in_ready = (state_q != S_ERR);
    assign accept       = bus.in_valid & bus.in_ready;
    assign n_rx         = {bus.in_data, n_lo_q};

    assign bus.im_wen   = im_wen_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_ld     = words_ld_q;

    // Next-state and next-output logic; every register holds unless a byte is accepted.
    always_comb begin
        state_d     = state_q;
        n_lo_d      = n_lo_q;
        n_d         = n_q;
        lane_d      = lane_q;
        word_d      = word_q;
        acc_d       = acc_q;
        im_wen_d    = 1'b0;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        cpu_rst_n_d = cpu_rst_n_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        words_ld_d  = words_ld_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept && bus.in_data == HDR_BYTE) begin
                    state_d = S_LEN0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    n_lo_d  = bus.in_data;
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    n_d        = n_rx;
                    words_ld_d = '0;
                    lane_d     = 2'd0;
                    acc_d      = 8'h00;
                    im_addr_d  = BASE_ADDR;
                    if (W_ADDR'(n_rx) > W_ADDR'(DEPTH_WORDS)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else if (n_rx == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    acc_d  = acc_q ^ bus.in_data;
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: word_d[7:0]   = bus.in_data;
                        2'd1: word_d[15:8]  = bus.in_data;
                        2'd2: word_d[23:16] = bus.in_data;
                        default: begin
                            // Fourth byte completes the word: write it next cycle.
                            im_wen_d   = 1'b1;
                            im_wdata_d = {bus.in_data, word_q};
                            im_addr_d  = BASE_ADDR + (W_ADDR'(words_ld_q) << 2);
                            words_ld_d = words_ld_q + W_CNT'(1);
                            if (words_ld_d == n_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (bus.in_data == acc_q) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        error_d     = 1'b0;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // A new header reloads: the core goes back into reset immediately.
                if (accept && bus.in_data == HDR_BYTE) begin
                    state_d     = S_LEN0;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_ERR: begin
                cpu_rst_n_d = 1'b0;
                error_d     = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            n_lo_q      <= 8'h00;
            n_q         <= '0;
            lane_q      <= 2'd0;
            word_q      <= 24'h0;
            acc_q       <= 8'h00;
            im_wen_q    <= 1'b0;
            im_addr_q   <= BASE_ADDR;
            im_wdata_q  <= 32'h0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_ld_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_lo_q      <= n_lo_d;
            n_q         <= n_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            im_wen_q    <= im_wen_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_ld_q  <= words_ld_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at frame issue,
// a monitor pops and compares on every im_wen, frame outcomes checked directly.
module tb_prog_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 256;
    localparam logic [7:0]  HDR   = 8'hA5;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rst_n, busy, done, error;
    logic [15:0] words_ld;

    prog_loader_if bus();

    prog_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .HDR_BYTE(HDR)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .words_ld  (words_ld)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    wr_t         exp_q[$];
    logic [31:0] words[$];
    wr_t         mon_e;
    bit          in_done_st = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.im_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected im_wen", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("im_addr", bus.im_addr, mon_e.addr);
                check("im_wdata", bus.im_wdata, mon_e.data);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, " im_wen"},    32'(bus.im_wen),   32'd0);
        check({tag, " im_addr"},   bus.im_addr,       BASE);
        check({tag, " im_wdata"},  bus.im_wdata,      32'd0);
        check({tag, " cpu_rst_n"}, 32'(cpu_rst_n),    32'd0);
        check({tag, " busy"},      32'(busy),         32'd0);
        check({tag, " done"},      32'(done),         32'd0);
        check({tag, " error"},     32'(error),        32'd0);
        check({tag, " words_ld"},  32'(words_ld),     32'd0);
        check({tag, " in_ready"},  32'(bus.in_ready), 32'd1);
    endtask

    // Present one byte, optionally after random idle gaps; returns at the
    // falling edge before the rising edge that transfers it.
    task automatic drive(input logic [7:0] b, input int gap_pct);
        int k;
        while (int'($urandom_range(99)) < gap_pct) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (bus.in_ready !== 1'b1) check("in_ready timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        in_done_st = 1'b0;
    endtask

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == HDR) b = 8'h5A;
        return b;
    endfunction

    // Send a whole frame built from 'words' and check the outcome.
    task automatic run_frame(input int n, input bit bad_csum, input int gap, input bit reload);
        logic [7:0] cs;
        logic [7:0] b;
        logic [31:0] w;
        cs = 8'h00;
        drive(HDR, gap);
        if (reload) begin
            idle(1);
            check("reload cpu_rst_n", 32'(cpu_rst_n), 32'd0);
            check("reload done",      32'(done),      32'd0);
            check("reload busy",      32'(busy),      32'd1);
        end
        drive(8'(n), gap);
        drive(8'(n >> 8), gap);
        if (n > DEPTH) begin
            idle(1);
            check("oversize error",     32'(error),        32'd1);
            check("oversize in_ready",  32'(bus.in_ready), 32'd0);
            check("oversize cpu_rst_n", 32'(cpu_rst_n),    32'd0);
            check("oversize busy",      32'(busy),         32'd0);
            in_done_st = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: BASE + 32'(4 * i), data: words[i]});
        end
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                b = w[8*j +: 8];
                cs = cs ^ b;
                drive(b, gap);
            end
        end
        drive(bad_csum ? (cs ^ 8'(1 << $urandom_range(7))) : cs, gap);
        idle(1);
        check("pending writes", 32'(exp_q.size()), 32'd0);
        check("words_ld",       32'(words_ld),     32'(n));
        check("busy after csum", 32'(busy),        32'd0);
        if (bad_csum) begin
            check("csum error",     32'(error),        32'd1);
            check("csum in_ready",  32'(bus.in_ready), 32'd0);
            check("csum cpu_rst_n", 32'(cpu_rst_n),    32'd0);
            check("csum done",      32'(done),         32'd0);
            in_done_st = 1'b0;
        end else begin
            check("done",      32'(done),      32'd1);
            check("error",     32'(error),     32'd0);
            check("cpu_rst_n", 32'(cpu_rst_n), 32'd1);
            in_done_st = 1'b1;
        end
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [31:0] w;
        int n;
        bit bad;

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;

        // Directed two-word frame, good checksum, then a reload from DONE.
        words.delete();
        words.push_back(32'h0000_0013);
        words.push_back(32'h0010_0093);
        run_frame(2, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) drive(junk_byte(), 0);
        idle(1);
        check("done holds on junk", 32'(done), 32'd1);
        words.delete();
        words.push_back(32'hDEAD_BEEF);
        run_frame(1, 1'b0, 0, 1'b1);

        // Same two-word frame with a bad checksum; error must persist.
        do_reset();
        words.delete();
        words.push_back(32'h0000_0013);
        words.push_back(32'h0010_0093);
        run_frame(2, 1'b1, 0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = HDR;
        end
        idle(1);
        check("error sticky",     32'(error),        32'd1);
        check("err in_ready",     32'(bus.in_ready), 32'd0);
        check("err cpu_rst_n",    32'(cpu_rst_n),    32'd0);

        // Leading junk dropped, then an empty frame.
        do_reset();
        drive(8'h00, 0);
        drive(8'hFF, 0);
        drive(8'h5A, 0);
        idle(1);
        check("idle busy on junk", 32'(busy), 32'd0);
        words.delete();
        run_frame(0, 1'b0, 0, 1'b0);

        // Length limits: exactly DEPTH accepted, DEPTH+1 rejected.
        rand_words(DEPTH);
        run_frame(DEPTH, 1'b0, 0, 1'b1);
        do_reset();
        run_frame(DEPTH + 1, 1'b0, 0, 1'b0);

        // Reset in the middle of the second word, with valid gaps.
        do_reset();
        rand_words(3);
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: BASE + 32'(4 * i), data: words[i]});
        drive(HDR, 40);
        drive(8'd3, 40);
        drive(8'd0, 40);
        for (int k = 0; k < 6; k++) begin
            w = words[k / 4];
            b = w[8*(k % 4) +: 8];
            drive(b, 40);
        end
        idle(1);
        check("mid words_ld",   32'(words_ld),     32'd1);
        check("mid busy",       32'(busy),         32'd1);
        check("mid writes left", 32'(exp_q.size()), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        in_done_st = 1'b0;
        rand_words(2);
        run_frame(2, 1'b0, 0, 1'b0);

        // Randomized frames with junk, gaps, reloads and occasional bad checksums.
        for (int t = 0; t < 12; t++) begin
            n   = int'($urandom_range(0, 6));
            bad = ($urandom_range(3) == 0);
            repeat ($urandom_range(0, 3)) drive(junk_byte(), 20);
            rand_words(n);
            run_frame(n, bad, ($urandom_range(1) == 1) ? 30 : 0, in_done_st);
            if (bad) do_reset();
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
